// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Shares one data bus between the CPU core and a DMA engine.
//   The core owns the bus by default; a DMA access takes two bus cycles
//   (setup, transfer) after the IDLE cycle in which it is granted, and the FSM
//   always returns to IDLE between DMA accesses.
//
//   Optional feature, enabled by defining ARB_STARVE_GUARD_EN:
//     a starve counter lets a DMA request that has waited STARVE_MAX IDLE
//     cycles win over a concurrent core request. Without the macro the core
//     has strict priority.
//
// Parameters
//   STARVE_MAX   IDLE cycles a DMA request may wait before it beats the core
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   core_addr/wdata/mode/reqw/reqs core bus request (mode 00 idle, 01 rd, 10 wr)
//   core_lock                      core in first cycle of a stalled load
//   core_rdata, core_wait          read data / stall to the core
//   dma_req, dma_addr/wdata/mode/reqw  DMA request (held until dma_ack)
//   dma_rdata, dma_ack             registered DMA read data / completion pulse
//   bus_addr/mode/reqw/reqs/wdata  shared bus drive
//   bus_rdata                      shared bus read data
module data_bus_arbiter #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [1:0]  core_mode,
    input  logic [1:0]  core_reqw,
    input  logic        core_reqs,
    input  logic        core_lock,
    output logic [31:0] core_rdata,
    output logic        core_wait,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_mode,
    input  logic [1:0]  dma_reqw,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] bus_addr,
    output logic [1:0]  bus_mode,
    output logic [1:0]  bus_reqw,
    output logic        bus_reqs,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DMA_SETUP = 2'd1,
        DMA_XFER  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic core_req;
    logic dma_rq;
    logic starve;
    logic grant;

    assign core_req = (core_mode != 2'b00);
    assign dma_rq   = dma_req && (dma_mode != 2'b00);

    // A grant is only decided in IDLE; core_lock protects the first cycle of
    // a stalled core load even against a starving DMA request.
    assign grant = (state == IDLE) && dma_rq && !core_lock && (!core_req || starve);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if ((state == IDLE) && dma_rq) begin
            if (grant) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign starve = (starve_cnt == CNT_MAX);
`else
    assign starve = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (grant) state_nx = DMA_SETUP;
            DMA_SETUP: state_nx = DMA_XFER;
            DMA_XFER:  state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus_addr   = core_addr;
        bus_wdata  = core_wdata;
        bus_mode   = core_mode;
        bus_reqw   = core_reqw;
        bus_reqs   = core_reqs;
        core_rdata = bus_rdata;
        core_wait  = 1'b0;
        dma_ack    = 1'b0;
        unique case (state)
            DMA_SETUP, DMA_XFER: begin
                bus_addr  = dma_addr;
                bus_wdata = dma_wdata;
                bus_mode  = dma_mode;
                bus_reqw  = dma_reqw;
                bus_reqs  = 1'b0;
                core_wait = core_req;
                dma_ack   = (state == DMA_XFER);
            end
            default: ;
        endcase
    end

    // DMA read data is captured on the edge that leaves DMA_XFER and held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rdata <= '0;
        end else if ((state == DMA_XFER) && (dma_mode == 2'b01)) begin
            dma_rdata <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

    localparam int unsigned SMAX = 8;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_addr, core_wdata;
    logic [1:0]  core_mode, core_reqw;
    logic        core_reqs, core_lock;
    logic [31:0] core_rdata;
    logic        core_wait;
    logic        dma_req;
    logic [31:0] dma_addr, dma_wdata;
    logic [1:0]  dma_mode, dma_reqw;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic [31:0] bus_addr;
    logic [1:0]  bus_mode, bus_reqw;
    logic        bus_reqs;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    data_bus_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_mode  (core_mode),
        .core_reqw  (core_reqw),
        .core_reqs  (core_reqs),
        .core_lock  (core_lock),
        .core_rdata (core_rdata),
        .core_wait  (core_wait),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_mode   (dma_mode),
        .dma_reqw   (dma_reqw),
        .dma_rdata  (dma_rdata),
        .dma_ack    (dma_ack),
        .bus_addr   (bus_addr),
        .bus_mode   (bus_mode),
        .bus_reqw   (bus_reqw),
        .bus_reqs   (bus_reqs),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: cycles elapsed since the grant cycle (-1: no access),
    // IDLE cycles a DMA request has waited, last DMA read result, and whether
    // a DMA request is pending (not yet granted).
    int          m_since   = -1;
    int          m_wait    = 0;
    logic [31:0] m_rdata   = '0;
    bit          m_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_since   = -1;
        m_wait    = 0;
        m_rdata   = '0;
        m_pending = 1'b0;
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic settle();
        bit acc;
        #2;
        acc = (m_since == 1) || (m_since == 2);
        chk("bus_addr",  bus_addr,  acc ? dma_addr  : core_addr);
        chk("bus_wdata", bus_wdata, acc ? dma_wdata : core_wdata);
        chk("bus_mode",  {30'd0, bus_mode}, {30'd0, acc ? dma_mode : core_mode});
        chk("bus_reqw",  {30'd0, bus_reqw}, {30'd0, acc ? dma_reqw : core_reqw});
        chk("bus_reqs",  {31'd0, bus_reqs}, {31'd0, acc ? 1'b0 : core_reqs});
        chk("core_wait", {31'd0, core_wait}, {31'd0, acc && (core_mode != 2'b00)});
        chk("dma_ack",   {31'd0, dma_ack},   {31'd0, m_since == 2});
        chk("dma_rdata", dma_rdata, m_rdata);
        if (!acc) chk("core_rdata", core_rdata, bus_rdata);
    endtask

    // Advance the model across a clock edge using the inputs held over it.
    task automatic tick();
        bit core_rq, dma_rq, grant;
        @(posedge clk);
        core_rq = (core_mode != 2'b00);
        dma_rq  = dma_req && (dma_mode != 2'b00);
        if (m_since == 2) begin
            if (dma_mode == 2'b01) m_rdata = bus_rdata;
            m_since   = -1;
            m_pending = 1'b0;
        end else if (m_since == 1) begin
            m_since = 2;
        end else begin
            grant = dma_rq && !core_lock && (!core_rq || (GUARD && (m_wait >= SMAX)));
            if (grant) begin
                m_since   = 1;
                m_wait    = 0;
                m_pending = 1'b0;
            end else begin
                if (dma_rq && (m_wait < SMAX)) m_wait = m_wait + 1;
                m_pending = dma_rq;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mode;
        logic [1:0]  reqw;
        logic        reqs;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [1:0]  e_mode;
        logic        e_reqs;
        logic [31:0] e_rdata;
        logic        e_wait;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0,         2'b01, 2'b10, 1'b0, 32'hCAFE_0000,
                    32'h0000_0100, 2'b01, 1'b0, 32'hCAFE_0000, 1'b0};
        vecs[1] = '{32'h0000_0104, 32'h5555_AAAA, 2'b10, 2'b00, 1'b1, 32'h0000_0001,
                    32'h0000_0104, 2'b10, 1'b1, 32'h0000_0001, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 32'h1234_0000, 2'b00, 2'b01, 1'b0, 32'hFFFF_FFFF,
                    32'hFFFF_FFFC, 2'b00, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0,         2'b01, 2'b00, 1'b1, 32'h0000_0080,
                    32'h8000_0000, 2'b01, 1'b1, 32'h0000_0080, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 2'b10, 2'b10, 1'b0, 32'h0,
                    32'h0000_0000, 2'b10, 1'b0, 32'h0,         1'b0};

        reset = 1'b0;
        core_addr = 32'h0000_0040; core_wdata = '0; core_mode = 2'b01;
        core_reqw = 2'b10; core_reqs = 1'b0; core_lock = 1'b0;
        dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_mode = 2'b00; dma_reqw = '0;
        bus_rdata = 32'h0BAD_F00D;

        // Reset state
        #3;
        chk("rst_dma_ack",   {31'd0, dma_ack},   32'd0);
        chk("rst_dma_rdata", dma_rdata,          32'd0);
        chk("rst_core_wait", {31'd0, core_wait}, 32'd0);
        chk("rst_bus_addr",  bus_addr,           32'h0000_0040);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Core-only pass-through vectors, each held for two cycles
        for (int i = 0; i < 5; i++) begin
            core_addr = vecs[i].addr; core_wdata = vecs[i].wdata; core_mode = vecs[i].mode;
            core_reqw = vecs[i].reqw; core_reqs = vecs[i].reqs; bus_rdata = vecs[i].rdata;
            for (int c = 0; c < 2; c++) begin
                settle();
                chk("vec_bus_addr",   bus_addr, vecs[i].e_addr);
                chk("vec_bus_mode",   {30'd0, bus_mode}, {30'd0, vecs[i].e_mode});
                chk("vec_bus_reqs",   {31'd0, bus_reqs}, {31'd0, vecs[i].e_reqs});
                chk("vec_core_rdata", core_rdata, vecs[i].e_rdata);
                chk("vec_core_wait",  {31'd0, core_wait}, {31'd0, vecs[i].e_wait});
                tick();
            end
        end

        // DMA write only
        core_mode = 2'b00; core_addr = 32'h0000_0010;
        dma_req = 1'b1; dma_mode = 2'b10; dma_addr = 32'h0000_2000;
        dma_wdata = 32'hDEAD_BEEF; dma_reqw = 2'b10;
        settle();
        chk("wr_grant_bus_addr", bus_addr, 32'h0000_0010);
        tick();
        settle();
        chk("wr_setup_addr",  bus_addr,  32'h0000_2000);
        chk("wr_setup_data",  bus_wdata, 32'hDEAD_BEEF);
        chk("wr_setup_ack",   {31'd0, dma_ack}, 32'd0);
        tick();
        settle();
        chk("wr_xfer_addr",   bus_addr,  32'h0000_2000);
        chk("wr_xfer_data",   bus_wdata, 32'hDEAD_BEEF);
        chk("wr_xfer_ack",    {31'd0, dma_ack}, 32'd1);
        tick();
        dma_req = 1'b0;
        settle();
        chk("wr_idle_ack",    {31'd0, dma_ack}, 32'd0);
        chk("wr_idle_addr",   bus_addr, 32'h0000_0010);
        tick();

        // DMA read, request dropped mid-access
        dma_req = 1'b1; dma_mode = 2'b01; dma_addr = 32'h0000_3000; bus_rdata = 32'h0;
        settle(); tick();
        dma_req = 1'b0;
        settle(); tick();
        bus_rdata = 32'h1234_5678;
        settle();
        chk("rd_xfer_ack", {31'd0, dma_ack}, 32'd1);
        tick();
        bus_rdata = 32'hFFFF_0000;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("rd_hold_rdata", dma_rdata, 32'h1234_5678);
            tick();
        end

        // Simultaneous core and DMA requests
        core_mode = 2'b01; core_addr = 32'h0000_0100;
        dma_req = 1'b1; dma_mode = 2'b01; dma_addr = 32'h0000_6000;
        if (GUARD) begin
            for (int c = 1; c <= SMAX + 1; c++) begin
                settle();
                chk("starve_core_wait", {31'd0, core_wait}, 32'd0);
                chk("starve_bus_addr",  bus_addr, 32'h0000_0100);
                tick();
            end
            settle();
            chk("starve_setup_wait", {31'd0, core_wait}, 32'd1);
            chk("starve_setup_addr", bus_addr, 32'h0000_6000);
            tick();
            settle();
            chk("starve_xfer_wait", {31'd0, core_wait}, 32'd1);
            chk("starve_xfer_ack",  {31'd0, dma_ack}, 32'd1);
            tick();
            dma_req = 1'b0;
            settle();
            chk("starve_after_wait", {31'd0, core_wait}, 32'd0);
            tick();
        end else begin
            for (int c = 0; c < 3 * SMAX; c++) begin
                settle();
                chk("strict_core_wait", {31'd0, core_wait}, 32'd0);
                chk("strict_bus_addr",  bus_addr, 32'h0000_0100);
                tick();
            end
            dma_req = 1'b0;
            settle(); tick();
        end

        // Grant blocked by core_lock, even once the starve condition holds
        core_mode = GUARD ? 2'b01 : 2'b00; core_addr = 32'h0000_0200; core_lock = 1'b1;
        dma_req = 1'b1; dma_mode = 2'b10; dma_addr = 32'h0000_7000; dma_wdata = 32'h0A0A_0A0A;
        for (int c = 0; c < SMAX + 4; c++) begin
            settle();
            chk("lock_bus_addr",  bus_addr, 32'h0000_0200);
            chk("lock_dma_ack",   {31'd0, dma_ack}, 32'd0);
            tick();
        end
        core_lock = 1'b0;
        settle();
        chk("unlock_grant_addr", bus_addr, 32'h0000_0200);
        tick();
        settle();
        chk("unlock_setup_addr", bus_addr, 32'h0000_7000);
        chk("unlock_setup_wait", {31'd0, core_wait}, {31'd0, GUARD});
        tick();
        settle(); tick();
        dma_req = 1'b0;
        settle(); tick();

        // Reset during DMA_SETUP
        core_mode = 2'b00; core_addr = 32'h0000_0400;
        dma_req = 1'b1; dma_mode = 2'b10; dma_addr = 32'h0000_5000;
        settle(); tick();
        core_mode = 2'b01;
        settle();
        chk("rstx_setup_addr", bus_addr, 32'h0000_5000);
        reset = 1'b0;
        #1;
        chk("rstx_bus_addr",  bus_addr, 32'h0000_0400);
        chk("rstx_core_wait", {31'd0, core_wait}, 32'd0);
        chk("rstx_dma_ack",   {31'd0, dma_ack},   32'd0);
        chk("rstx_dma_rdata", dma_rdata, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rstx_held_ack",  {31'd0, dma_ack}, 32'd0);
        chk("rstx_held_addr", bus_addr, 32'h0000_0400);
        reset = 1'b1;
        // Counter restarts from zero: the full starve interval applies again
        dma_mode = 2'b01;
        for (int c = 0; c < SMAX + 5; c++) begin
            settle(); tick();
        end
        dma_req = 1'b0;
        settle(); tick();
        settle(); tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            core_addr  = $urandom;
            core_wdata = $urandom;
            core_mode  = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
            core_reqw  = 2'($urandom_range(0, 3));
            core_reqs  = 1'($urandom_range(0, 1));
            core_lock  = ($urandom_range(0, 3) == 0);
            bus_rdata  = $urandom;
            if (m_since == -1 && !m_pending) begin
                dma_req   = ($urandom_range(0, 2) != 0);
                dma_mode  = 2'($urandom_range(0, 2));
                dma_addr  = $urandom;
                dma_wdata = $urandom;
                dma_reqw  = 2'($urandom_range(0, 3));
            end else if (m_since == 1 && $urandom_range(0, 3) == 0) begin
                dma_req = 1'b0;
            end
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
